// File: rtl/pe_pkg.sv
// Shared types and derived constants for the PE sequencer slice.
package pe_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_W,
        WAIT_W,
        LOAD_A,
        WAIT_A,
        RUN,
        WAIT_C,
        DRAIN,
        DONE
    } pe_state_t;

    localparam int unsigned DEF_KERNEL_SIZE     = 3;
    localparam int unsigned DEF_ACTIVATION_SIZE = 5;

    // Word counts for a square tile and number of sliding passes per layer.
    function automatic int unsigned words_for_edge(input int unsigned edge_len);
        return edge_len * edge_len;
    endfunction

    function automatic int unsigned passes_for(input int unsigned k_size,
                                               input int unsigned a_size);
        return a_size - k_size + 1;
    endfunction

    localparam int unsigned W_WORDS    = words_for_edge(DEF_KERNEL_SIZE);
    localparam int unsigned A_WORDS    = words_for_edge(DEF_ACTIVATION_SIZE);
    localparam int unsigned NUM_PASSES = passes_for(DEF_KERNEL_SIZE, DEF_ACTIVATION_SIZE);

endpackage

// File: rtl/pe_result_buffer.sv
// Captures one result word per PE and streams them out in PE order.
module pe_result_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_PE     = 4,
    parameter int unsigned PE_W       = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         capture,
    input  logic [NUM_PE*DATA_WIDTH-1:0] pe_out,
    input  logic [7:0]                   iter,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [PE_W-1:0]              out_pe,
    output logic [7:0]                   out_iter,
    output logic                         drain_done
);

    localparam logic [PE_W-1:0] IDX_LAST = PE_W'(NUM_PE - 1);

    logic [DATA_WIDTH-1:0] res_q [NUM_PE];
    logic                  active;
    logic [PE_W-1:0]       out_idx;

    // Snapshot all PE outputs, then walk the index on each accepted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_PE; i++) begin
                res_q[i] <= '0;
            end
            active  <= 1'b0;
            out_idx <= '0;
        end else if (capture) begin
            for (int unsigned i = 0; i < NUM_PE; i++) begin
                res_q[i] <= pe_out[i*DATA_WIDTH +: DATA_WIDTH];
            end
            active  <= 1'b1;
            out_idx <= '0;
        end else if (active && out_ready) begin
            if (out_idx == IDX_LAST) begin
                active <= 1'b0;
            end else begin
                out_idx <= out_idx + 1'b1;
            end
        end
    end

    // Outputs are driven from registers only and read as zero while idle.
    always_comb begin
        out_valid  = active;
        out_data   = active ? res_q[out_idx] : '0;
        out_pe     = active ? out_idx : '0;
        out_iter   = active ? iter : '0;
        drain_done = active && out_ready && (out_idx == IDX_LAST);
    end

endmodule

// File: rtl/pe_sequencer.sv
// Loads weights/activations into each PE, runs the compute passes and
// streams results out iteration-major, PE-minor.
module pe_sequencer
    import pe_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH      = 16,
    parameter  int unsigned NUM_PE          = 4,
    parameter  int unsigned KERNEL_SIZE     = 3,
    parameter  int unsigned ACTIVATION_SIZE = 5,
    localparam int unsigned PE_W            = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_start,
    output logic                         busy,
    output logic                         layer_done,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_ready,
    output logic [NUM_PE-1:0]            pe_load_weight,
    output logic [NUM_PE-1:0]            pe_load_activation,
    output logic [DATA_WIDTH-1:0]        pe_load_data,
    output logic [NUM_PE-1:0]            pe_start,
    input  logic [NUM_PE-1:0]            pe_load_done,
    input  logic [NUM_PE-1:0]            pe_compute_done,
    input  logic [NUM_PE*DATA_WIDTH-1:0] pe_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [PE_W-1:0]              out_pe,
    output logic [7:0]                   out_iter
);

    localparam int unsigned WW     = words_for_edge(KERNEL_SIZE);
    localparam int unsigned AW     = words_for_edge(ACTIVATION_SIZE);
    localparam int unsigned PASSES = passes_for(KERNEL_SIZE, ACTIVATION_SIZE);
    localparam int unsigned CNT_W  = $clog2(WW + AW + 1);

    localparam logic [CNT_W-1:0] W_LAST    = CNT_W'(WW - 1);
    localparam logic [CNT_W-1:0] A_LAST    = CNT_W'(AW - 1);
    localparam logic [7:0]       ITER_LAST = 8'(PASSES - 1);
    localparam logic [PE_W-1:0]  PE_LAST   = PE_W'(NUM_PE - 1);

    pe_state_t         state;
    logic [PE_W-1:0]   pe_idx;
    logic [CNT_W-1:0]  word_cnt;
    logic [7:0]        iter;
    logic [NUM_PE-1:0] sticky;
    logic [NUM_PE-1:0] done_all;
    logic [NUM_PE-1:0] pe_sel;
    logic              accept;
    logic              capture;
    logic              drain_done;

    assign accept   = in_valid & in_ready;
    assign pe_sel   = NUM_PE'(1) << pe_idx;
    // A done pulse landing in the completing cycle still counts.
    assign done_all = sticky | pe_compute_done;
    assign capture  = (state == WAIT_C) && (&done_all);

    // Shared load bus: one strobe, only on an accepted word.
    always_comb begin
        pe_load_weight     = '0;
        pe_load_activation = '0;
        pe_load_data       = '0;
        if (accept) begin
            pe_load_data = in_data;
            if (state == LOAD_W) begin
                pe_load_weight = pe_sel;
            end else if (state == LOAD_A) begin
                pe_load_activation = pe_sel;
            end
        end
    end

    // Sequencer FSM; busy/in_ready/pe_start/layer_done are set on the
    // transition into the state that owns them so they are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pe_idx     <= '0;
            word_cnt   <= '0;
            iter       <= '0;
            sticky     <= '0;
            busy       <= 1'b0;
            in_ready   <= 1'b0;
            pe_start   <= '0;
            layer_done <= 1'b0;
        end else begin
            pe_start   <= '0;
            layer_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state    <= LOAD_W;
                        pe_idx   <= '0;
                        word_cnt <= '0;
                        iter     <= '0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                    end
                end
                LOAD_W: begin
                    if (accept) begin
                        if (word_cnt == W_LAST) begin
                            word_cnt <= '0;
                            in_ready <= 1'b0;
                            state    <= WAIT_W;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                WAIT_W: begin
                    if (pe_load_done[pe_idx]) begin
                        word_cnt <= '0;
                        in_ready <= 1'b1;
                        state    <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (accept) begin
                        if (word_cnt == A_LAST) begin
                            word_cnt <= '0;
                            in_ready <= 1'b0;
                            state    <= WAIT_A;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                WAIT_A: begin
                    if (pe_load_done[pe_idx]) begin
                        if (pe_idx != PE_LAST) begin
                            pe_idx   <= pe_idx + 1'b1;
                            in_ready <= 1'b1;
                            state    <= LOAD_W;
                        end else begin
                            pe_start <= '1;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    state <= WAIT_C;
                end
                WAIT_C: begin
                    if (&done_all) begin
                        sticky <= '0;
                        state  <= DRAIN;
                    end else begin
                        sticky <= done_all;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        iter <= iter + 1'b1;
                        if (iter == ITER_LAST) begin
                            layer_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            pe_start <= '1;
                            state    <= RUN;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    pe_result_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_PE     (NUM_PE),
        .PE_W       (PE_W)
    ) u_result_buffer (
        .clk        (clk),
        .reset      (reset),
        .capture    (capture),
        .pe_out     (pe_out),
        .iter       (iter),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_pe     (out_pe),
        .out_iter   (out_iter),
        .drain_done (drain_done)
    );

endmodule

// File: tb/tb_pe_sequencer.sv
// Scoreboard bench for pe_sequencer at default parameters.
module tb_pe_sequencer;

    localparam int DW  = 16;
    localparam int NPE = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_start;
    logic              busy;
    logic              layer_done;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_ready;
    logic [NPE-1:0]    pe_load_weight;
    logic [NPE-1:0]    pe_load_activation;
    logic [DW-1:0]     pe_load_data;
    logic [NPE-1:0]    pe_start;
    logic [NPE-1:0]    pe_load_done;
    logic [NPE-1:0]    pe_compute_done;
    logic [NPE*DW-1:0] pe_out;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_pe;
    logic [7:0]        out_iter;

    pe_sequencer #(
        .DATA_WIDTH      (DW),
        .NUM_PE          (NPE),
        .KERNEL_SIZE     (3),
        .ACTIVATION_SIZE (5)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cfg_start          (cfg_start),
        .busy               (busy),
        .layer_done         (layer_done),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_ready           (in_ready),
        .pe_load_weight     (pe_load_weight),
        .pe_load_activation (pe_load_activation),
        .pe_load_data       (pe_load_data),
        .pe_start           (pe_start),
        .pe_load_done       (pe_load_done),
        .pe_compute_done    (pe_compute_done),
        .pe_out             (pe_out),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_pe             (out_pe),
        .out_iter           (out_iter)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          act;
        int          pe;
        logic [15:0] data;
    } load_t;

    typedef struct {
        logic [15:0] data;
        int          pe;
        int          it;
    } res_t;

    load_t lq[$];
    res_t  sbq[$];

    int n_chk  = 0;
    int n_fail = 0;

    int wcnt[NPE];
    int acnt[NPE];
    int wtot = 0;
    int atot = 0;
    int res_cnt = 0;
    int done_cnt = 0;
    int sc = 0;
    int pass_cnt = 0;
    int cur_pass = 0;
    logic [NPE-1:0] prev_start = '0;
    logic prev_valid = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got event-missing expected event-present", nm);
    endtask

    task automatic finish_tb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    function automatic logic [15:0] pv(input int i, input int p);
        return 16'((i + 1) * 17 + p * 256);
    endfunction

    // PE model: load-done levels follow the words actually delivered.
    always_comb begin
        for (int i = 0; i < NPE; i++) begin
            pe_load_done[i] = (wcnt[i] == 9 && acnt[i] == 0) || (acnt[i] == 25);
        end
    end

    // Compute-done staggered 2, 5, 5, 9 cycles after pe_start; results valid only on cycle 9.
    assign pe_compute_done = {sc == 9, sc == 5, sc == 5, sc == 2};

    always_comb begin
        for (int i = 0; i < NPE; i++) begin
            pe_out[i*DW +: DW] = (sc == 9) ? pv(i, cur_pass) : (16'hBAD0 ^ 16'(i));
        end
    end

    // Stimulus side of the compute phase: push expected results at each pe_start.
    always @(posedge clk) begin
        if (prev_start != '0) chk("start_one_cycle", 64'(pe_start), 64'h0);
        if (reset) begin
            sbq.delete();
            pass_cnt <= 0;
        end else if (cfg_start && !busy) begin
            pass_cnt <= 0;
        end else if (pe_start != '0) begin
            chk("start_all", 64'(pe_start), 64'hF);
            if (pass_cnt == 0) begin
                chk("weight_loads", 64'(wtot), 64'd36);
                chk("act_loads", 64'(atot), 64'd100);
            end
            for (int i = 0; i < NPE; i++) begin
                sbq.push_back('{data: pv(i, pass_cnt), pe: i, it: pass_cnt});
            end
            cur_pass <= pass_cnt;
            pass_cnt <= pass_cnt + 1;
        end
        if (pe_start != '0) sc <= 1;
        else if (sc >= 30) sc <= 0;
        else if (sc != 0) sc <= sc + 1;
        prev_start <= pe_start;
    end

    // Load bus monitor.
    always @(negedge clk) begin
        if (reset || (cfg_start && !busy)) begin
            for (int i = 0; i < NPE; i++) begin
                wcnt[i] = 0;
                acnt[i] = 0;
            end
            wtot = 0;
            atot = 0;
        end
        if (in_valid && in_ready) begin
            if (lq.size() == 0) begin
                fail_now("load_expected_entry");
            end else begin
                load_t e;
                logic [NPE-1:0] oh;
                e  = lq.pop_front();
                oh = NPE'(1) << e.pe;
                chk("load_weight", 64'(pe_load_weight), e.act ? 64'h0 : 64'(oh));
                chk("load_act", 64'(pe_load_activation), e.act ? 64'(oh) : 64'h0);
                chk("load_data", 64'(pe_load_data), 64'(e.data));
            end
        end else begin
            chk("load_idle", 64'({pe_load_weight, pe_load_activation}), 64'h0);
        end
        for (int i = 0; i < NPE; i++) begin
            if (pe_load_weight[i]) begin
                wcnt[i]++;
                wtot++;
            end
            if (pe_load_activation[i]) begin
                acnt[i]++;
                atot++;
            end
        end
    end

    // Result monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (reset || (cfg_start && !busy)) begin
            res_cnt  = 0;
            done_cnt = 0;
        end
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                fail_now("result_expected_entry");
            end else begin
                res_t r;
                r = sbq.pop_front();
                chk("out_data", 64'(out_data), 64'(r.data));
                chk("out_pe", 64'(out_pe), 64'(r.pe));
                chk("out_iter", 64'(out_iter), 64'(r.it));
            end
            res_cnt++;
        end
        if (out_valid && !prev_valid) chk("capture_cycle", 64'(sc), 64'd10);
        prev_valid = out_valid;
        if (layer_done) done_cnt++;
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_layer_done"}, 64'(layer_done), 64'h0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'h0);
        chk({tag, "_load_w"}, 64'(pe_load_weight), 64'h0);
        chk({tag, "_load_a"}, 64'(pe_load_activation), 64'h0);
        chk({tag, "_load_data"}, 64'(pe_load_data), 64'h0);
        chk({tag, "_pe_start"}, 64'(pe_start), 64'h0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'h0);
        chk({tag, "_out_data"}, 64'(out_data), 64'h0);
        chk({tag, "_out_pe"}, 64'(out_pe), 64'h0);
        chk({tag, "_out_iter"}, 64'(out_iter), 64'h0);
    endtask

    task automatic start_layer();
        @(posedge clk); #1;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic send_word(input bit act, input int pe, input int idx);
        logic [15:0] d;
        bit got;
        d   = {act ? 4'h8 : 4'h0, 4'(pe), 8'(idx)};
        got = 1'b0;
        lq.push_back('{act: act, pe: pe, data: d});
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            fail_now("in_ready_timeout");
            finish_tb();
        end
        @(posedge clk); #1;
    endtask

    task automatic send_stream(input bit toggle_act);
        for (int pe = 0; pe < NPE; pe++) begin
            for (int w = 0; w < 9; w++) send_word(1'b0, pe, w);
            for (int a = 0; a < 25; a++) begin
                if (toggle_act && a != 0) begin
                    in_valid = 1'b0;
                    in_data  = 16'hFFFF;
                    @(posedge clk); #1;
                end
                send_word(1'b1, pe, a);
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_valid();
        bit got;
        got = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            fail_now("out_valid_timeout");
            finish_tb();
        end
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            if (done_cnt != 0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            fail_now("layer_done_timeout");
            finish_tb();
        end
        #1;
    endtask

    initial begin
        logic [15:0] held;
        bit got;
        reset     = 1'b1;
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < NPE; i++) begin
            wcnt[i] = 0;
            acnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;

        // Layer 1: continuous stream, backpressure on the first result.
        out_ready = 1'b0;
        start_layer();
        send_stream(1'b0);
        wait_valid();
        held = out_data;
        chk("bp_first_data", 64'(held), 64'h0011);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_held", 64'(out_valid), 64'h1);
            chk("bp_data_stable", 64'(out_data), 64'(held));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done();
        chk("l1_results", 64'(res_cnt), 64'd12);
        chk("l1_done_pulses", 64'(done_cnt), 64'd1);
        chk("l1_sb_empty", 64'(sbq.size()), 64'd0);
        chk("l1_busy_after", 64'(busy), 64'h0);

        // Layer 2: gapped activations, stray cfg_start while draining.
        start_layer();
        send_stream(1'b1);
        wait_valid();
        @(posedge clk); #1;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        wait_done();
        repeat (5) @(posedge clk);
        #1;
        chk("l2_busy_after", 64'(busy), 64'h0);
        chk("l2_done_pulses", 64'(done_cnt), 64'd1);
        chk("l2_results", 64'(res_cnt), 64'd12);

        // Layer 3: reset while waiting for compute.
        start_layer();
        send_stream(1'b0);
        got = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (sc == 3 && busy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            fail_now("wait_c_timeout");
            finish_tb();
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("midreset");
        reset = 1'b0;
        lq.delete();
        repeat (20) @(posedge clk);
        #1;
        chk("l3_no_done", 64'(done_cnt), 64'd0);
        chk("l3_no_results", 64'(res_cnt), 64'd0);
        chk("l3_idle", 64'(busy), 64'h0);

        // Layer 4: normal layer after the abandoned one.
        start_layer();
        send_stream(1'b0);
        wait_done();
        chk("l4_results", 64'(res_cnt), 64'd12);
        chk("l4_done_pulses", 64'(done_cnt), 64'd1);
        chk("l4_sb_empty", 64'(sbq.size()), 64'd0);

        finish_tb();
    end

endmodule

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 16, word width; NUM_PE, default 4, number of processing elements driven; KERNEL_SIZE, default 3, filter edge; ACTIVATION_SIZE, default 5, activation edge.
REQ-002 SHALL have ports, clock and reset first: clk in 1, clock; reset in 1, synchronous, active-high.
REQ-003 cfg_start in 1, begin layer; busy out 1, sequencer active; layer_done out 1, one-cycle completion pulse.
REQ-004 in_valid in 1, in_data in DATA_WIDTH, in_ready out 1: load stream; per PE, KERNEL_SIZE**2 weights then ACTIVATION_SIZE**2 activations, PE0 first.
REQ-005 pe_load_weight out NUM_PE, pe_load_activation out NUM_PE, pe_load_data out DATA_WIDTH: shared load bus.
REQ-006 pe_start out NUM_PE, pe_load_done in NUM_PE, pe_compute_done in NUM_PE, pe_out in NUM_PE*DATA_WIDTH: PE control/status; PE i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 out_valid out 1, out_ready in 1, out_data out DATA_WIDTH, out_pe out clog2(NUM_PE), out_iter out 8: result stream.

Function
REQ-008 SHALL implement the states IDLE, LOAD_W, WAIT_W, LOAD_A, WAIT_A, RUN, WAIT_C, DRAIN, DONE.
REQ-009 IDLE: busy=0; cfg_start=1 -> LOAD_W, pe_idx=0, word_cnt=0, iter=0; cfg_start is ignored outside IDLE.
REQ-010 LOAD_W: in_ready=1; on each in_valid&in_ready, drive pe_load_weight[pe_idx]=1 and pe_load_data=in_data in the same cycle; after KERNEL_SIZE**2 words -> WAIT_W.
REQ-011 WAIT_W: in_ready=0; pe_load_done[pe_idx]=1 -> LOAD_A, word_cnt=0.
REQ-012 LOAD_A/WAIT_A: same as LOAD_W/WAIT_W, using pe_load_activation and ACTIVATION_SIZE**2 words; on exit from WAIT_A, if pe_idx<NUM_PE-1 then increment pe_idx and go to LOAD_W, else go to RUN.
REQ-013 Only one pe_load_* bit SHALL be high in any cycle, and only while a word is accepted; in_valid low stalls with no pulse.
REQ-014 RUN: pulse all pe_start bits for exactly one cycle -> WAIT_C.
REQ-015 WAIT_C: set a sticky bit for each pe_compute_done pulse; when all NUM_PE bits are set, clear the bits, capture all pe_out into a result buffer, and go to DRAIN with out_idx=0.
REQ-016 DRAIN: out_valid=1, out_data=buffer[out_idx], out_pe=out_idx, out_iter=iter; data SHALL hold stable while out_ready=0; after the handshake on out_idx=NUM_PE-1, increment iter; if iter==ACTIVATION_SIZE-KERNEL_SIZE (the last pass) -> DONE, else -> RUN.
REQ-017 DONE: layer_done=1 for one cycle -> IDLE.
REQ-018 Total passes SHALL equal ACTIVATION_SIZE-KERNEL_SIZE+1 (3 at defaults); results SHALL be iteration-major, PE-minor.
REQ-019 A pe_compute_done that arrives in the same cycle as the final sticky set SHALL be counted; compute_done seen outside WAIT_C SHALL be ignored.
REQ-020 busy=1 in every state except IDLE.

Reset
REQ-021 reset SHALL force IDLE and zero all counters, sticky bits and the result buffer; reset mid-operation SHALL abandon the layer with no layer_done.
REQ-022 Reset values: busy, layer_done, in_ready, pe_load_weight, pe_load_activation, pe_load_data, pe_start, out_valid, out_data, out_pe and out_iter SHALL all be 0.

Structure
REQ-023 The state enum type and the derived constants W_WORDS=KERNEL_SIZE**2, A_WORDS=ACTIVATION_SIZE**2 and NUM_PASSES SHALL live in the shared package pe_pkg.
REQ-024 The result buffer plus drain logic SHALL be a single sub-module, pe_result_buffer; all other logic is flat.

Verification
REQ-025 Defaults, stream of 4*(9+25) words with in_valid always high -> exactly 36 weight and 100 activation load pulses, each to the correct PE index, then the first pe_start=4'b1111.
REQ-026 in_valid toggling 1/0 during LOAD_A -> no load pulse in cycles with in_valid low; word count unchanged.
REQ-027 PE compute_done pulses staggered on cycles 2, 5, 5 and 9 after pe_start -> exactly one capture on cycle 9; out_data equals the pe_out values 0x0011, 0x0022, 0x0033, 0x0044 in PE order.
REQ-028 out_ready held low for 5 cycles during DRAIN -> out_valid stays high and out_data is stable; 12 total results with out_iter 0, 1, 2; layer_done pulses once.
REQ-029 reset asserted in WAIT_C -> next cycle IDLE with all outputs 0; a new cfg_start completes a full layer normally.
REQ-030 cfg_start pulsed during DRAIN -> ignored; the layer finishes and returns to IDLE once.
